// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Op codes follow funct3 so the decoder can pass its field straight through.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  function automatic logic is_signed_a(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  // Divide-class ops share funct3[2]; REM/REMU additionally share funct3[1].
  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(muldiv_op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// Shared W-bit adder/subtractor; carry=1 on subtract means a >= b (no borrow).
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per clock.
// Division by zero and signed overflow can short-circuit straight to DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  muldiv_op_e      op_q;
  logic [XLEN-1:0] hi, lo, opb;
  logic            neg_res;
  logic [CNT_W-1:0] cnt;

  assign in_ready = (state == IDLE);

  // Request decode: magnitudes, sign of the final result and fast-path detection.
  muldiv_op_e      req_op;
  logic            sa, sb, b_zero, ovf, fast, req_neg;
  logic [XLEN-1:0] mag_a, mag_b, fast_result;

  assign req_op = muldiv_op_e'(in_op);
  assign sa     = is_signed_a(req_op) & in_a[XLEN-1];
  assign sb     = is_signed_b(req_op) & in_b[XLEN-1];
  assign mag_a  = sa ? -in_a : in_a;
  assign mag_b  = sb ? -in_b : in_b;
  assign b_zero = (in_b == '0);
  assign ovf    = is_signed_b(req_op) && is_div(req_op) && (in_a == MIN_NEG) && (&in_b);
  assign fast   = FAST_ZERO && is_div(req_op) && (b_zero || ovf);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fast_result = '0;
    if (b_zero) fast_result = is_rem(req_op) ? in_a : '1;
    else        fast_result = is_rem(req_op) ? '0 : in_a;
  end

  // Quotient keeps the all-ones divide-by-zero answer even when the dividend is negative.
  always_comb begin
    req_neg = sa ^ sb;
    if (is_rem(req_op))      req_neg = sa;
    else if (is_div(req_op)) req_neg = (sa ^ sb) && !b_zero;
  end

  // One adder serves both loops: add multiplicand to the high half, or trial-subtract divisor.
  logic [XLEN:0] as_a, as_sum;
  logic          as_carry;

  assign as_a = is_div(op_q) ? {hi, lo[XLEN-1]} : {1'b0, hi};

  muldiv_addsub #(.W(XLEN + 1)) u_addsub (
    .a     (as_a),
    .b     ({1'b0, opb}),
    .sub   (is_div(op_q)),
    .sum   (as_sum),
    .carry (as_carry)
  );

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fix_result;

  assign prod_s = neg_res ? -{hi, lo} : {hi, lo};

  always_comb begin
    fix_result = '0;
    unique case (op_q)
      OP_MUL:                      fix_result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_result = neg_res ? -lo : lo;
      OP_REM, OP_REMU:             fix_result = neg_res ? -hi : hi;
      default:                     fix_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_MUL;
      hi         <= '0;
      lo         <= '0;
      opb        <= '0;
      neg_res    <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: if (in_valid && !kill) begin
          op_q    <= req_op;
          neg_res <= req_neg;
          cnt     <= '0;
          hi      <= '0;
          lo      <= is_div(req_op) ? mag_a : mag_b;
          opb     <= is_div(req_op) ? mag_b : mag_a;
          if (fast) begin
            out_result <= fast_result;
            out_zero   <= (fast_result == '0);
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: if (kill) begin
          state <= IDLE;
        end else begin
          if (is_div(op_q)) begin
            hi <= as_carry ? as_sum[XLEN-1:0] : as_a[XLEN-1:0];
            lo <= {lo[XLEN-2:0], as_carry};
          end else if (lo[0]) begin
            {hi, lo} <= {as_sum, lo[XLEN-1:1]};
          end else begin
            {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
        end
        FIX: if (kill) begin
          state <= IDLE;
        end else begin
          out_result <= fix_result;
          out_zero   <= (fix_result == '0);
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: if (kill || out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes model results, monitor pops on each output handshake.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_zero;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .FAST_ZERO(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .kill       (kill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics straight from the RV32M rules using 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint p;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed_ovf;
    signed_ovf = (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    return (op >= 3'd4 && (b == 0 || signed_ovf)) ? 1 : 34;
  endfunction

  // Monitor: samples mid-low-phase, a transfer happens at the following rising edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready && !kill) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("result", out_result, e);
        check("zero", 32'(out_zero), 32'(e == 0));
      end
    end
  end

  task automatic accept_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    @(posedge clk);
    if (push) exp_q.push_back(ref_model(op, a, b));
    #1;
    in_valid = 1'b0;
    in_op = 3'($urandom);
    in_a = $urandom;
    in_b = $urandom;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    int lat = 1;
    logic [31:0] e;
    e = ref_model(op, a, b);
    out_ready = (stall == 0);
    accept_op(op, a, b, 1'b1);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_latency(op, a, b)));
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        check("hold_result", out_result, e);
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("idle_after", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    do_op(OP_MUL,    32'd23, 32'd42, 0);
    do_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(OP_DIV,    -32'sd42, 32'd23, 0);
    do_op(OP_REM,    -32'sd42, 32'd23, 0);
    do_op(OP_DIVU,   32'd42, 32'd23, 0);
    do_op(OP_REMU,   32'd42, 32'd23, 0);
    do_op(OP_DIVU,   32'd42, 32'd0, 0);
    do_op(OP_REM,    32'd42, 32'd0, 0);
    do_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(OP_DIV,    -32'sd7, 32'd0, 0);

    // Back-pressure for 5 clocks, then an immediate follow-up accept.
    do_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5);
    do_op(OP_DIV,   32'd1000, -32'sd3, 0);

    for (int i = 0; i < 40; i++)
      do_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2));

    // Kill mid-CALC: back to IDLE next clock and no result ever appears.
    out_ready = 1'b1;
    accept_op(OP_DIVU, 32'd1000, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_out_valid", 32'(out_valid), 32'd0);
    check("kill_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("kill_no_result", 32'(seen), 32'd0);

    // Kill in IDLE blocks the accept.
    @(negedge clk);
    kill = 1'b1;
    in_valid = 1'b1;
    in_op = OP_MUL;
    @(posedge clk);
    #1;
    check("kill_idle_block", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    kill = 1'b0;
    do_op(OP_MUL, 32'd3, 32'd5, 0);

    // Reset mid-CALC clears the held result immediately.
    accept_op(OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", out_result, 32'd0);
    check("rst_mid_zero", 32'(out_zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(OP_REMU, 32'd100, 32'd7, 0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
